// File: rtl/microwave_ctrl.sv
//==============================================================================
// Module   : microwave_ctrl
// Purpose  : Top-level sequencing controller for a microwave oven. It builds
//            an MM:SS cook time from BCD keypad digits, reacts to the
//            start/stop/clear buttons and the door switch, counts the time
//            down on a 1 Hz tick, and drives the magnetron and done lamp.
//
// Ports    : clk            in   system clock
//            reset          in   synchronous, active-high reset
//            tick_1hz       in   one-cycle pulse per second
//            digit_valid    in   one-cycle strobe, digit holds a new key
//            digit[3:0]     in   BCD key value (10..15 ignored)
//            startn         in   start button level, active low
//            stopn          in   stop button level, active low
//            clearn         in   clear button level, active low
//            door_closed    in   1 = door closed
//            keypad_enablen out  active-low keypad encoder enable
//            time_bcd[15:0] out  {min_tens, min_units, sec_tens, sec_units}
//            mag_on         out  magnetron enable (gated by the door)
//            done           out  cook-complete level
//            state[2:0]     out  current state code
//
// Options  : MICROWAVE_QUICK_START_EN - when defined, start with a zero time
//            (IDLE, or ENTRY at 0000) loads 00:30 and begins cooking.
//
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module microwave_ctrl #(
   parameter int MAX_DIGITS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick_1hz,
   input  logic        digit_valid,
   input  logic [3:0]  digit,
   input  logic        startn,
   input  logic        stopn,
   input  logic        clearn,
   input  logic        door_closed,
   output logic        keypad_enablen,
   output logic [15:0] time_bcd,
   output logic        mag_on,
   output logic        done,
   output logic [2:0]  state
);

   // The MM:SS datapath below is hard-wired to four digits.
   generate
      if (MAX_DIGITS != 4) begin : g_bad_max_digits
         $error("microwave_ctrl supports only MAX_DIGITS = 4");
      end
   endgenerate

`ifdef MICROWAVE_QUICK_START_EN
   localparam logic QUICK_START = 1'b1;
`else
   localparam logic QUICK_START = 1'b0;
`endif

   localparam logic [15:0] QUICK_TIME = 16'h0030;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ENTRY = 3'd1,
      S_COOK  = 3'd2,
      S_PAUSE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [15:0] time_q;
   logic [15:0] time_d;
   logic [15:0] time_dec;

   // Previous button levels reset to 0 so a button held low through reset
   // must be released before it can generate an event.
   logic start_prev;
   logic stop_prev;
   logic clear_prev;

   logic start_ev;
   logic stop_ev;
   logic clear_ev;
   logic door_open;
   logic digit_ok;

   assign start_ev  = start_prev & ~startn;
   assign stop_ev   = stop_prev  & ~stopn;
   assign clear_ev  = clear_prev & ~clearn;
   assign door_open = ~door_closed;
   assign digit_ok  = digit_valid & (digit <= 4'd9);

   //---------------------------------------------------------------------------
   // BCD decrement of MM:SS. Seconds tens borrow to 5; values above 5 typed by
   // the user simply count down. Only used when time is non-zero.
   //---------------------------------------------------------------------------
   always_comb begin
      time_dec = time_q;
      if (time_q[3:0] != 4'd0) begin
         time_dec[3:0] = time_q[3:0] - 4'd1;
      end else begin
         time_dec[3:0] = 4'd9;
         if (time_q[7:4] != 4'd0) begin
            time_dec[7:4] = time_q[7:4] - 4'd1;
         end else begin
            time_dec[7:4] = 4'd5;
            if (time_q[11:8] != 4'd0) begin
               time_dec[11:8] = time_q[11:8] - 4'd1;
            end else begin
               time_dec[11:8]  = 4'd9;
               time_dec[15:12] = time_q[15:12] - 4'd1;
            end
         end
      end
   end

   //---------------------------------------------------------------------------
   // Next-state logic. Within each state the branches are ordered
   // clear > stop > door open > start > digit > tick; an event with no effect
   // in the current state does not mask a lower-priority one.
   //---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      time_d  = time_q;
      case (state_q)
         S_IDLE: begin
            time_d = 16'h0000;
            if (QUICK_START && start_ev && door_closed) begin
               state_d = S_COOK;
               time_d  = QUICK_TIME;
            end else if (digit_ok) begin
               state_d = S_ENTRY;
               time_d  = {12'h000, digit};
            end
         end
         S_ENTRY: begin
            if (clear_ev) begin
               state_d = S_IDLE;
               time_d  = 16'h0000;
            end else if (start_ev && door_closed && (time_q != 16'h0000)) begin
               state_d = S_COOK;
            end else if (QUICK_START && start_ev && door_closed) begin
               state_d = S_COOK;
               time_d  = QUICK_TIME;
            end else if (digit_ok) begin
               time_d = {time_q[11:0], digit};
            end
         end
         S_COOK: begin
            if (clear_ev) begin
               state_d = S_IDLE;
               time_d  = 16'h0000;
            end else if (stop_ev || door_open) begin
               state_d = S_PAUSE;
            end else if (tick_1hz) begin
               // 0001 (or a degenerate 0000) finishes on this same edge.
               if (time_q <= 16'h0001) begin
                  state_d = S_DONE;
                  time_d  = 16'h0000;
               end else begin
                  time_d = time_dec;
               end
            end
         end
         S_PAUSE: begin
            if (clear_ev || stop_ev) begin
               state_d = S_IDLE;
               time_d  = 16'h0000;
            end else if (start_ev && door_closed) begin
               state_d = S_COOK;
            end
         end
         S_DONE: begin
            time_d = 16'h0000;
            if (clear_ev || stop_ev || door_open) begin
               state_d = S_IDLE;
            end else if (digit_ok) begin
               state_d = S_ENTRY;
               time_d  = {12'h000, digit};
            end
         end
         default: begin
            state_d = S_IDLE;
            time_d  = 16'h0000;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         time_q     <= 16'h0000;
         start_prev <= 1'b0;
         stop_prev  <= 1'b0;
         clear_prev <= 1'b0;
      end else begin
         state_q    <= state_d;
         time_q     <= time_d;
         start_prev <= startn;
         stop_prev  <= stopn;
         clear_prev <= clearn;
      end
   end

   // Door gate is combinational so the magnetron drops in the cycle the door
   // opens, one edge before the state reaches PAUSE.
   assign mag_on         = (state_q == S_COOK) & door_closed;
   assign done           = (state_q == S_DONE);
   assign keypad_enablen = ~((state_q == S_IDLE) | (state_q == S_ENTRY) |
                             (state_q == S_DONE));
   assign time_bcd       = time_q;
   assign state          = state_q;

endmodule

`default_nettype wire

// File: doc/microwave_ctrl.md
# microwave_ctrl

Top-level sequencing controller for the microwave oven. It takes BCD digits and their valid strobe from the keypad encoder path and builds a four-digit MM:SS cook time. It reacts to start/stop/clear buttons and the door switch, counts the time down on the 1 Hz tick, and drives the magnetron enable and completion indicator. It also gates the keypad encoder through `keypad_enablen`.

## Interface
Parameters:
- `MAX_DIGITS`, 4 — number of BCD digits held; fixed MM:SS layout, only 4 is supported.

Ports:
- `clk` in 1 — system clock (same domain as the keypad encoder).
- `reset` in 1 — synchronous, active-high.
- `tick_1hz` in 1 — one-cycle pulse per second, synchronous to `clk`.
- `digit_valid` in 1 — one-cycle pulse: `digit` holds a new debounced key.
- `digit` in 4 — BCD key value; codes 10–15 are ignored.
- `startn`, `stopn`, `clearn` in 1 each — active-low button levels, pre-debounced.
- `door_closed` in 1 — 1 = door closed.
- `keypad_enablen` out 1 — active-low enable to the keypad encoder.
- `time_bcd` out 16 — {min_tens, min_units, sec_tens, sec_units}.
- `mag_on` out 1 — magnetron enable.
- `done` out 1 — cook-complete indicator (level).
- `state` out 3 — current FSM state code, for display and debug.

## Operation
- Button events are falling edges of `startn`/`stopn`/`clearn`.
  - Each button has a previous-level register that resets to 0.
  - A button held low through reset produces no event until it is released and pressed again.
- Event priority in any cycle: clear > stop > door open > start > digit > tick.
- States (code):
  - IDLE (0): `time_bcd`=0000, mag off, keypad enabled. A valid digit loads `{12'h000, digit}` and moves to ENTRY. Start is ignored (see Configuration).
  - ENTRY (1): a valid digit shifts in, `time_bcd <= {time_bcd[11:0], digit}`; the MS digit is discarded. Start with `door_closed`=1 and time ≠ 0000 → COOK. Start with the door open → stays in ENTRY. Clear → IDLE, time 0000.
  - COOK (2): keypad disabled. On `tick_1hz`, decrement in BCD:
    - sec_units wraps 0→9 with borrow.
    - sec_tens 0 with borrow → 5, borrowing from minutes.
    - Minutes decrement as 2-digit BCD.
    - Seconds tens values above 5 entered by the user (e.g. 0090) count down naturally.
    - Decrementing 0001 → 0000 enters DONE on the same edge.
    - Stop or door open → PAUSE. Clear → IDLE.
  - PAUSE (3): mag off, time held, keypad disabled, digits ignored. Start with door closed → COOK. Stop or clear → IDLE with time 0000.
  - DONE (4): `done`=1, mag off, time 0000. Clear, stop, or door open → IDLE. A valid digit → ENTRY with that digit loaded.
- `mag_on` is `mag_reg & door_closed`.
  - `mag_reg` is 1 only in COOK.
  - The combinational door gate removes magnetron drive in the same cycle the door opens, before the state moves to PAUSE.
- `keypad_enablen` = 0 in IDLE, ENTRY and DONE; 1 otherwise.
- Invalid state codes (5–7) return to IDLE on the next edge.

## Timing
- Reset values: `state`=IDLE, `time_bcd`=16'h0000, `mag_on`=0, `done`=0, `keypad_enablen`=0. Reset overrides all inputs.
- Every update (state, time, `done`, `keypad_enablen`) is visible one edge after the event cycle.
- A digit pulse at edge N appears in `time_bcd` after edge N+1.
- Start accepted at edge N: `state`=COOK and `mag_on`=1 after edge N+1.
- A `tick_1hz` in the same cycle a start is accepted is not counted; the first decrement is on the next tick.
- A `tick_1hz` coincident with stop, clear or door open is discarded.
- `door_closed` falling: `mag_on` drops combinationally in that cycle, and `state`=PAUSE after the next edge.

## Configuration
- `MICROWAVE_QUICK_START_EN`:
  - Defined: start in IDLE, or in ENTRY with time 0000, with the door closed loads 0030 and enters COOK on the same edge.
  - Not defined: start with time 0000 is ignored in every state.

## Test plan
- Reset, then digits 1,3,0 → `time_bcd`=16'h0130, `state`=1, `mag_on`=0.
- Digits 1,2,3,4,5 → `time_bcd`=16'h2345 (first digit dropped). Digit 4'hC → no change.
- Load 0100, start, 3 ticks → 0059, 0058, 0057. Continue to 0000 → `state`=4, `done`=1, `mag_on`=0 on the same edge as the last decrement.
- During COOK at 0030, drop `door_closed` → `mag_on`=0 in the same cycle and `state`=3. Tick while paused → time stays 0030. Close the door, then start → COOK resumes from 0030.
- Stop and tick in the same cycle during COOK → PAUSE, no decrement. Clear in PAUSE → IDLE, 0000. `startn` held low through reset → no COOK entry.
- With `MICROWAVE_QUICK_START_EN` defined: start in IDLE with door closed → `time_bcd`=16'h0030, COOK. Without it: the same stimulus leaves the block in IDLE.
